// File: rtl/noc_arb_pkg.sv
// Shared types for the NoC output-port arbiter.
// Holds the FSM encoding and the default idle-lock timeout.
package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int default_hold_timeout();
    return 64;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin winner search: first set request at or after ptr, wrapping.
// Uses a doubled request vector so the wrap needs no second priority chain.
module rr_priority_picker #(
  parameter int IN_N = 5
) (
  input  logic [IN_N-1:0]         req_i,
  input  logic [$clog2(IN_N)-1:0] ptr_i,
  output logic [IN_N-1:0]         gnt_oh_o,
  output logic [$clog2(IN_N)-1:0] gnt_idx_o,
  output logic                    found_o
);

  localparam int IW = $clog2(IN_N);

  logic [2*IN_N-1:0] dbl;
  logic [2*IN_N-1:0] msk;
  int                win;

  always_comb begin
    dbl = {req_i, req_i};
    msk = '0;
    for (int i = 0; i < 2*IN_N; i++) begin
      msk[i] = dbl[i] && (i >= int'(ptr_i));
    end
  end

  // Scan downward so the last hit is the lowest masked index.
  always_comb begin
    found_o = 1'b0;
    win     = 0;
    for (int i = 2*IN_N-1; i >= 0; i--) begin
      if (msk[i]) begin
        found_o = 1'b1;
        win     = (i >= IN_N) ? i - IN_N : i;
      end
    end
    gnt_idx_o = IW'(win);
    gnt_oh_o  = found_o ? (IN_N'(1) << win) : '0;
  end

endmodule

// File: rtl/rr_wormhole_arbiter.sv
// Round-robin wormhole arbiter for one NoC output port.
// Optional forced release on idle lock: define RR_ARB_HOLD_TIMEOUT_EN.
module rr_wormhole_arbiter
  import noc_arb_pkg::*;
#(
  parameter int IN_N         = 5,
  parameter int HOLD_TIMEOUT = default_hold_timeout()
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [IN_N-1:0]         req_i,
  input  logic [IN_N-1:0]         last_i,
  input  logic                    ready_i,
  output logic [IN_N-1:0]         gnt_o,
  output logic [$clog2(IN_N)-1:0] gnt_idx_o,
  output logic                    gnt_vld_o,
  output logic                    timeout_o
);

  localparam int IW = $clog2(IN_N);

  if (IN_N < 2 || IN_N > 16) begin : g_bad_in_n
    $error("rr_wormhole_arbiter: IN_N must be 2..16");
  end
  if (HOLD_TIMEOUT < 1) begin : g_bad_hold
    $error("rr_wormhole_arbiter: HOLD_TIMEOUT must be >= 1");
  end

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IN_N-1:0] gnt_q, gnt_d;
  logic            tmo_q, tmo_d;

  logic [IN_N-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            locked;
  logic            xfer;
  logic            hit;
  logic            rel;
  logic [IW-1:0]   ptr_nxt;

  rr_priority_picker #(
    .IN_N (IN_N)
  ) u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .found_o   (pick_vld)
  );

  assign locked  = (state_q == ARB_LOCKED);
  assign xfer    = locked & req_i[idx_q] & ready_i;
  assign rel     = (xfer & last_i[idx_q]) | hit;
  assign ptr_nxt = (idx_q == IW'(IN_N-1)) ? '0 : idx_q + 1'b1;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_TIMEOUT+1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the idle cycle that would bring the count to HOLD_TIMEOUT.
  assign hit = locked & ~xfer & (cnt_q == CW'(HOLD_TIMEOUT-1));

  always_comb begin
    cnt_d = '0;
    if (locked && !xfer && !hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        if (rel) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    idx_d = idx_q;
    gnt_d = gnt_q;
    tmo_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          gnt_d = pick_oh;
          idx_d = pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (rel) begin
          gnt_d = '0;
          ptr_d = ptr_nxt;
          tmo_d = hit;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign gnt_vld_o = locked;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_rr_wormhole_arbiter.sv
// Directed bench for rr_wormhole_arbiter (IN_N=5, HOLD_TIMEOUT=8).
// Honours RR_ARB_HOLD_TIMEOUT_EN for the forced-release scenario.
module tb_rr_wormhole_arbiter;

  localparam int N = 5;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] last_i = '0;
  logic         ready_i = 1'b0;
  logic [N-1:0] gnt_o;
  logic [2:0]   gnt_idx_o;
  logic         gnt_vld_o;
  logic         timeout_o;

  int total = 0;
  int bad   = 0;

  rr_wormhole_arbiter #(
    .IN_N         (N),
    .HOLD_TIMEOUT (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .last_i    (last_i),
    .ready_i   (ready_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .gnt_vld_o (gnt_vld_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic grant_is(input string tag, input int idx);
    chk({tag, "_vld"}, int'(gnt_vld_o), 1);
    chk({tag, "_idx"}, int'(gnt_idx_o), idx);
    chk({tag, "_oh"}, int'(gnt_o), 1 << idx);
  endtask

  task automatic idle_is(input string tag);
    chk({tag, "_vld"}, int'(gnt_vld_o), 0);
    chk({tag, "_oh"}, int'(gnt_o), 0);
  endtask

  task automatic do_reset();
    req_i   = '0;
    last_i  = '0;
    ready_i = 1'b0;
    rst_i   = 1'b1;
    tick();
    rst_i   = 1'b0;
  endtask

  // Single-flit packet from one input: moves ptr to idx+1.
  task automatic one_flit(input int idx);
    req_i   = N'(1 << idx);
    last_i  = N'(1 << idx);
    ready_i = 1'b1;
    tick();
    tick();
  endtask

  int rot [6] = '{0, 1, 2, 3, 4, 0};
  bit rdy [7] = '{1, 0, 1, 0, 1, 0, 1};

  initial begin
    // reset state
    tick();
    idle_is("rst");
    chk("rst_idx", int'(gnt_idx_o), 0);
    chk("rst_tmo", int'(timeout_o), 0);
    rst_i = 1'b0;

    // async reset while locked
    req_i   = 5'b11111;
    last_i  = 5'b11111;
    ready_i = 1'b0;
    tick();
    grant_is("pre_arst", 0);
    #3 rst_i = 1'b1;
    #1;
    idle_is("arst");
    chk("arst_idx", int'(gnt_idx_o), 0);
    #1 rst_i = 1'b0;
    tick();
    grant_is("post_arst", 0);

    // rotation with single-flit packets
    do_reset();
    req_i   = 5'b11111;
    last_i  = 5'b11111;
    ready_i = 1'b1;
    foreach (rot[k]) begin
      tick();
      grant_is($sformatf("rot%0d", k), rot[k]);
      tick();
      idle_is($sformatf("rot_gap%0d", k));
    end

    // wormhole hold: 4-flit packet on input 2, ready toggling
    do_reset();
    one_flit(1);
    req_i   = 5'b00101;
    last_i  = 5'b00000;
    ready_i = 1'b1;
    tick();
    grant_is("wh_head", 2);
    foreach (rdy[c]) begin
      ready_i = rdy[c];
      last_i  = (c == 6) ? 5'b00100 : 5'b00000;
      tick();
      if (c < 6) begin
        grant_is($sformatf("wh_hold%0d", c), 2);
      end
    end
    idle_is("wh_rel");
    last_i = '0;
    tick();
    grant_is("wh_next", 0);

    // request drop while locked, others requesting
    do_reset();
    req_i   = 5'b00010;
    last_i  = 5'b00000;
    ready_i = 1'b1;
    tick();
    grant_is("drop_gnt", 1);
    req_i = 5'b11101;
    for (int i = 0; i < 10; i++) tick();
    grant_is("drop_hold", 1);
    req_i = 5'b00010;
    tick();
    grant_is("drop_resume", 1);
    last_i = 5'b00010;
    tick();
    idle_is("drop_rel");

    // pointer wrap 4 -> 0, then ptr = 1
    do_reset();
    one_flit(3);
    req_i  = 5'b00011;
    last_i = 5'b00011;
    tick();
    grant_is("wrap_gnt", 0);
    tick();
    idle_is("wrap_rel");
    tick();
    grant_is("wrap_ptr1", 1);

    // idle lock on input 3
    do_reset();
    req_i   = 5'b01000;
    last_i  = 5'b00000;
    ready_i = 1'b0;
    tick();
    grant_is("to_gnt", 3);
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("to_early_tmo%0d", i), int'(timeout_o), 0);
      chk($sformatf("to_early_vld%0d", i), int'(gnt_vld_o), 1);
    end
    tick();
    chk("to_pulse", int'(timeout_o), 1);
    idle_is("to_rel");
    req_i = 5'b11000;
    tick();
    chk("to_pulse_end", int'(timeout_o), 0);
    grant_is("to_ptr4", 4);
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("hold_tmo%0d", i), int'(timeout_o), 0);
    end
    grant_is("hold_forever", 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
